// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the PC sequencer.
//   state_t      - sequencer states (FETCH, EXEC, HALT)
//   SEL_*        - next-PC multiplexer select codes
//   F3_*         - funct3 branch condition codes
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_OFFSET = 2'b01;
    localparam logic [1:0] SEL_ALU    = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// branch_cond: resolves a branch condition from the ALU flags of rs1-rs2.
// Ports:
//   funct3 - branch condition code
//   zf, cf, vf, sf - ALU flags (cf=1 means no borrow, rs1 >= rs2 unsigned)
//   taken  - condition holds
module branch_cond
    import pc_seq_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zf,
    input  logic       cf,
    input  logic       vf,
    input  logic       sf,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zf;
            F3_BNE:  taken = !zf;
            F3_BLT:  taken = (sf != vf);
            F3_BGE:  taken = (sf == vf);
            F3_BLTU: taken = !cf;
            F3_BGEU: taken = cf;
            default: taken = 1'b0;   // 010/011 are not branch encodings
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences each instruction
// through a fetch handshake and a one-cycle execute slot.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   imem_req / imem_ack  - fetch request for address pc / instruction valid
//   branch, jal, jalr    - decoded control-flow class
//   halt_req             - decoded ECALL/EBREAK
//   funct3, zf/cf/vf/sf  - branch condition and ALU flags
//   next_pc              - next-PC multiplexer output, loaded at end of EXEC
//   pc, pc_sel           - current PC and multiplexer select
//   inst_valid           - execute strobe (one cycle per instruction)
//   halted, misaligned, fetch_err - stop status; the cause flags are sticky
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        branch,
    input  logic        jal,
    input  logic        jalr,
    input  logic        halt_req,
    input  logic [2:0]  funct3,
    input  logic        zf,
    input  logic        cf,
    input  logic        vf,
    input  logic        sf,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic [1:0]  pc_sel,
    output logic        inst_valid,
    output logic        halted,
    output logic        misaligned,
    output logic        fetch_err
);

    localparam int CW = $clog2(FETCH_TIMEOUT + 1);
    // Counter holds the number of ack-less cycles already spent, so the
    // FETCH_TIMEOUT-th cycle without ack is the one seeing CNT_LAST.
    localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          taken;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .zf     (zf),
        .cf     (cf),
        .vf     (vf),
        .sf     (sf),
        .taken  (taken)
    );

    assign imem_req   = (state == ST_FETCH);
    assign inst_valid = (state == ST_EXEC);
    assign halted     = (state == ST_HALT);

    always_comb begin
        pc_sel = SEL_PC4;
        if (state == ST_EXEC) begin
            if (jalr)                pc_sel = SEL_ALU;
            else if (jal)            pc_sel = SEL_OFFSET;
            else if (branch && taken) pc_sel = SEL_OFFSET;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            wait_cnt   <= '0;
            misaligned <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        state    <= ST_EXEC;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= ST_HALT;
                        fetch_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_EXEC: begin
                    // Halt request wins over any redirect; PC holds.
                    if (halt_req) begin
                        state <= ST_HALT;
                    end else if (pc_sel != SEL_PC4 && next_pc[1:0] != 2'b00) begin
                        state      <= ST_HALT;
                        misaligned <= 1'b1;
                    end else begin
                        pc       <= next_pc;
                        state    <= ST_FETCH;
                        wait_cnt <= '0;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TMO      = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic        branch = 1'b0, jal = 1'b0, jalr = 1'b0, halt_req = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic        zf = 1'b0, cf = 1'b0, vf = 1'b0, sf = 1'b0;
    logic [31:0] next_pc, pc;
    logic [1:0]  pc_sel;
    logic        inst_valid, halted, misaligned, fetch_err;

    logic [31:0] off = 32'd0, tgt = 32'd0;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_halt, m_mis;

    always #5 clk = ~clk;

    // external next-PC multiplexer
    assign next_pc = (pc_sel == 2'b01) ? pc + off :
                     (pc_sel == 2'b10) ? tgt : pc + 32'd4;

    pc_sequencer #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
        .branch(branch), .jal(jal), .jalr(jalr), .halt_req(halt_req),
        .funct3(funct3), .zf(zf), .cf(cf), .vf(vf), .sf(sf),
        .next_pc(next_pc), .pc(pc), .pc_sel(pc_sel), .inst_valid(inst_valid),
        .halted(halted), .misaligned(misaligned), .fetch_err(fetch_err)
    );

    // Branch decision from the operand values themselves.
    function automatic logic cond_true(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level model: returns expected select, advances m_* state.
    function automatic logic [1:0] model_inst(input logic br, input logic jl, input logic jr,
                                              input logic hr, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] o, input logic [31:0] t);
        logic [1:0]  s;
        logic [31:0] dest;
        s = jr ? 2'b10 : jl ? 2'b01 : (br && cond_true(f3, a, b)) ? 2'b01 : 2'b00;
        dest = (s == 2'b10) ? t : (s == 2'b01) ? m_pc + o : m_pc + 32'd4;
        if (hr) m_halt = 1'b1;
        else if (s != 2'b00 && dest[1:0] != 2'b00) begin m_halt = 1'b1; m_mis = 1'b1; end
        else m_pc = dest;
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = RESET_PC; m_halt = 1'b0; m_mis = 1'b0;
    endtask

    // Called at a negedge in FETCH; returns what was seen during EXEC.
    task automatic drive_inst(input int waits, input logic br, input logic jl, input logic jr,
                              input logic hr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] o, input logic [31:0] t,
                              output logic [1:0] sel, output logic iv);
        logic [31:0] d;
        imem_ack = 1'b0;
        repeat (waits) @(negedge clk);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        d = a - b;
        zf = (d == 32'd0); sf = d[31]; cf = (a >= b);
        vf = (a[31] != b[31]) && (d[31] != a[31]);
        branch = br; jal = jl; jalr = jr; halt_req = hr; funct3 = f3; off = o; tgt = t;
        #1;
        sel = pc_sel; iv = inst_valid;
        @(negedge clk);
        branch = 1'b0; jal = 1'b0; jalr = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== RESET_PC || imem_req !== 1'b1 || pc_sel !== 2'b00 || inst_valid !== 1'b0 ||
            halted !== 1'b0 || misaligned !== 1'b0 || fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL reset: pc=%h req=%b sel=%b iv=%b h=%b m=%b fe=%b", pc, imem_req,
                     pc_sel, inst_valid, halted, misaligned, fetch_err);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        logic [1:0] s, es; logic iv;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin
                failures++;
                $display("FAIL seq_fetch: iv=%b req=%b want 0/1", inst_valid, imem_req);
            end
            es = model_inst(0, 0, 0, 0, 3'b0, 0, 0, 0, 0);
            drive_inst(0, 0, 0, 0, 0, 3'b0, 0, 0, 0, 0, s, iv);
            checks++;
            if (s !== es || iv !== 1'b1 || pc !== m_pc) begin
                failures++;
                $display("FAIL seq: sel=%b iv=%b pc=%h want sel=%b iv=1 pc=%h", s, iv, pc, es, m_pc);
            end
        end
    endtask

    task automatic test_branch();
        logic [1:0] s, es; logic iv;
        es = model_inst(1, 0, 0, 0, 3'b000, 7, 7, 32'h40 - m_pc, 0);
        drive_inst(0, 1, 0, 0, 0, 3'b000, 7, 7, 32'h40 - pc, 0, s, iv);
        checks++;
        if (s !== es || pc !== 32'h40) begin
            failures++;
            $display("FAIL beq_taken: sel=%b pc=%h want sel=%b pc=00000040", s, pc, es);
        end
        es = model_inst(1, 0, 0, 0, 3'b001, 7, 7, 32'h80, 0);
        drive_inst(0, 1, 0, 0, 0, 3'b001, 7, 7, 32'h80, 0, s, iv);
        checks++;
        if (s !== es || pc !== m_pc || pc !== 32'h44) begin
            failures++;
            $display("FAIL bne_not: sel=%b pc=%h want sel=%b pc=%h", s, pc, es, m_pc);
        end
    endtask

    task automatic test_funct3();
        logic [1:0] s, es; logic iv;
        logic [2:0]  f3s [8];
        logic [31:0] av [2];
        logic [31:0] bv [2];
        f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
        av = '{32'hFFFF_FFFF, 32'd1};
        bv = '{32'd1, 32'hFFFF_FFFF};
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 8; k++) begin
                es = model_inst(1, 0, 0, 0, f3s[k], av[p], bv[p], 32'h20, 0);
                drive_inst(0, 1, 0, 0, 0, f3s[k], av[p], bv[p], 32'h20, 0, s, iv);
                checks++;
                if (s !== es || pc !== m_pc) begin
                    failures++;
                    $display("FAIL funct3 f3=%b a=%h: sel=%b pc=%h want sel=%b pc=%h",
                             f3s[k], av[p], s, pc, es, m_pc);
                end
            end
    endtask

    task automatic test_random();
        logic [1:0] s, es; logic iv;
        logic br, jl, jr; logic [2:0] f3; logic [31:0] a, b, o, t; int w;
        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(0, 5);
            br = $urandom_range(0, 1); jl = ($urandom_range(0, 3) == 0); jr = ($urandom_range(0, 3) == 0);
            f3 = 3'($urandom); a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            o = {$urandom, 2'b00}; t = {$urandom, 2'b00};
            es = model_inst(br, jl, jr, 0, f3, a, b, o, t);
            drive_inst(w, br, jl, jr, 0, f3, a, b, o, t, s, iv);
            checks++;
            if (s !== es || iv !== 1'b1 || pc !== m_pc || halted !== 1'b0) begin
                failures++;
                $display("FAIL random #%0d: sel=%b iv=%b pc=%h h=%b want sel=%b pc=%h",
                         i, s, iv, pc, halted, es, m_pc);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] s, es; logic iv;
        es = model_inst(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC - m_pc, 0);
        drive_inst(0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC - pc, 0, s, iv);
        es = model_inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_inst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s, iv);
        checks++;
        if (pc !== 32'd0 || m_pc !== 32'd0 || halted !== 1'b0 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL wrap: pc=%h h=%b m=%b want pc=00000000 h=0 m=0", pc, halted, misaligned);
        end
    endtask

    task automatic test_jalr_misaligned();
        logic [1:0] s, es; logic iv; logic [31:0] p0;
        p0 = pc;
        es = model_inst(0, 0, 1, 0, 0, 0, 0, 0, 32'h102);
        drive_inst(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h102, s, iv);
        checks++;
        if (s !== es || halted !== 1'b1 || misaligned !== m_mis || pc !== p0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL jalr_mis: sel=%b h=%b m=%b pc=%h req=%b want sel=10 h=1 m=1 pc=%h req=0",
                     s, halted, misaligned, pc, imem_req, p0);
        end
        imem_ack = 1'b1;
        repeat (4) @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== p0 || fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL halt_sticky: h=%b req=%b iv=%b pc=%h fe=%b", halted, imem_req, inst_valid, pc, fetch_err);
        end
        // asynchronous reset out of HALT, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || misaligned !== 1'b0 || pc !== RESET_PC || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL async_rst_halt: h=%b m=%b pc=%h req=%b", halted, misaligned, pc, imem_req);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: h=%b req=%b fe=%b after %0d cycles", halted, imem_req, fetch_err, TMO - 1);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || fetch_err !== 1'b1 || misaligned !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout: h=%b fe=%b m=%b req=%b want 1/1/0/0", halted, fetch_err, misaligned, imem_req);
        end
        do_reset();
    endtask

    task automatic test_ack_late();
        logic [1:0] s, es; logic iv;
        for (int i = 0; i < 2; i++) begin
            es = model_inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
            drive_inst(TMO - 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, s, iv);
            checks++;
            if (iv !== 1'b1 || pc !== m_pc || halted !== 1'b0 || fetch_err !== 1'b0) begin
                failures++;
                $display("FAIL ack_late #%0d: iv=%b pc=%h h=%b fe=%b want pc=%h", i, iv, pc, halted, fetch_err, m_pc);
            end
        end
    endtask

    task automatic test_halt_jal();
        logic [1:0] s, es; logic iv; logic [31:0] p0;
        p0 = pc;
        es = model_inst(0, 1, 0, 1, 0, 0, 0, 32'h6, 0);
        drive_inst(0, 0, 1, 0, 1, 0, 0, 0, 32'h6, 0, s, iv);
        checks++;
        if (s !== es || halted !== m_halt || pc !== p0 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL halt_jal: sel=%b h=%b pc=%h m=%b want sel=01 h=1 pc=%h m=0", s, halted, pc, misaligned, p0);
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        logic [1:0] s, es; logic iv;
        es = model_inst(0, 1, 0, 0, 0, 0, 0, 32'h100, 0);
        drive_inst(0, 0, 1, 0, 0, 0, 0, 0, 32'h100, 0, s, iv);
        @(negedge clk);                    // mid-FETCH, no ack
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== RESET_PC || imem_req !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL async_rst_fetch: pc=%h req=%b h=%b want pc=%h", pc, imem_req, halted, RESET_PC);
        end
        do_reset();
        // abort in EXEC: no strobe, no PC update escapes
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; jal = 1'b1; off = 32'h200;
        #2 rst_n = 1'b0;
        #1;
        jal = 1'b0;
        checks++;
        if (pc !== RESET_PC || inst_valid !== 1'b0 || pc_sel !== 2'b00) begin
            failures++;
            $display("FAIL async_rst_exec: pc=%h iv=%b sel=%b", pc, inst_valid, pc_sel);
        end
        @(posedge clk); #1;
        checks++;
        if (pc !== RESET_PC || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_hold: pc=%h iv=%b", pc, inst_valid);
        end
        do_reset();
    endtask

    initial begin
        m_pc = RESET_PC; m_halt = 1'b0; m_mis = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_funct3();
        test_random();
        test_wrap();
        test_jalr_misaligned();
        test_timeout();
        test_ack_late();
        test_halt_jal();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control block that owns the program counter and drives the 2-bit select of the next-PC multiplexer (PC+4 / PC+offset / ALU target). It sequences each instruction through a fetch handshake with instruction memory and a one-cycle execute slot. It resolves branch conditions from ALU flags, loads the multiplexer output into the PC, and halts on ECALL/EBREAK, a misaligned target, or a fetch timeout. It sits between instruction memory, the control decoder, the ALU flags and the next-PC multiplexer.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FETCH_TIMEOUT, 16, max cycles `imem_req` may wait for `imem_ack` (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request for address `pc`
- imem_ack  in  1  instruction word valid this cycle
- branch  in  1  decoded B-type instruction
- jal  in  1  decoded JAL
- jalr  in  1  decoded JALR
- halt_req  in  1  decoded ECALL/EBREAK
- funct3  in  3  branch condition code
- zf, cf, vf, sf  in  1 each  ALU flags of rs1−rs2 (cf=1 ⇔ no borrow ⇔ rs1 ≥ rs2 unsigned)
- next_pc  in  32  next-PC multiplexer output
- pc  out  32  current PC
- pc_sel  out  2  multiplexer select: 00 PC+4, 01 PC+offset, 10 ALU target
- inst_valid  out  1  execute strobe; gates register-file/memory writes
- halted  out  1  core stopped
- misaligned  out  1  sticky, halt caused by target[1:0]≠0
- fetch_err  out  1  sticky, halt caused by fetch timeout

## Operation
- States: FETCH, EXEC, HALT. Reset enters FETCH.
- FETCH: `imem_req`=1. If `imem_ack`=1, go to EXEC. The wait counter increments each cycle without ack. If the counter reaches FETCH_TIMEOUT, go to HALT and set `fetch_err`.
- EXEC: `inst_valid`=1 for exactly one cycle. `pc_sel` is driven combinationally by priority:
  - jalr → 10
  - jal → 01
  - branch taken → 01
  - otherwise → 00
- Branch taken by funct3:
  - 000 zf
  - 001 !zf
  - 100 sf≠vf
  - 101 sf=vf
  - 110 !cf
  - 111 cf
  - 010/011 never taken
- End of EXEC:
  - halt_req=1 → HALT, PC unchanged.
  - pc_sel≠00 and next_pc[1:0]≠00 → HALT, set `misaligned`, PC unchanged.
  - Otherwise PC ← next_pc and go to FETCH.
- JALR bit-0 clearing is done in the ALU target path, not here; next_pc[0]=1 with sel=10 is treated as misaligned.
- HALT: terminal state. All strobes 0, `halted`=1. Exit only via rst_n.
- Outside EXEC, `pc_sel`=00 and `inst_valid`=0.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, imem_req=1 (combinational from state), pc_sel=00, inst_valid=0, halted=0, misaligned=0, fetch_err=0, wait counter=0.
- Asserting rst_n mid-instruction aborts it immediately. No PC update or write strobe escapes.
- Minimum 2 cycles per instruction (ack in the first FETCH cycle). Each ack-wait cycle adds one.
- `imem_ack` is ignored outside FETCH. The counter clears on entering FETCH.
- The PC changes only on the EXEC→FETCH edge. `pc` is stable through FETCH and EXEC.
- Simultaneous halt_req and jump/branch: the halt wins and the PC holds. `misaligned` is not set.
- PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 → 0) with no error.

## Structure
- Package `pc_seq_pkg`:
  - state encoding (FETCH, EXEC, HALT)
  - PC select codes (SEL_PC4=2'b00, SEL_OFFSET=2'b01, SEL_ALU=2'b10)
  - funct3 branch codes (BEQ, BNE, BLT, BGE, BLTU, BGEU)
- Sub-module `branch_cond`: combinational funct3+flags → taken.
- The FSM, PC register and timeout counter stay in `pc_sequencer`.

## Test plan
- Reset release, ack in the first FETCH cycle, no control bits, next_pc=pc+4 → pc goes 0→4→8, one inst_valid pulse every 2 cycles, pc_sel=00.
- BEQ zf=1 with next_pc=0x40 → pc_sel=01 in EXEC, pc=0x40. Repeat with BNE zf=1 → pc_sel=00, pc=pc+4.
- All six funct3 codes against flag vectors for (−1 vs 1) and (1 vs −1) signed/unsigned → BLT/BGEU taken and BGE/BLTU not, then the reverse; funct3=010 is never taken.
- JALR with next_pc=0x102 → HALT next cycle, misaligned=1, pc unchanged, no further imem_req.
- FETCH_TIMEOUT=16, ack held low → fetch_err=1 and halted=1 after exactly 16 FETCH cycles. Ack arriving on cycle 15 proceeds normally.
- halt_req with jal in the same EXEC → halted=1, pc unchanged. rst_n low mid-FETCH → pc=RESET_PC and flags cleared asynchronously.
